// File: rtl/ibuf_compact_queue.sv
// Instruction buffer between fetch and decode: compacts sparse fetch groups into a
// circular queue and presents up to DECODE_WIDTH in-order entries per cycle.
module ibuf_compact_queue #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int ILEN         = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic                                     fe_valid_i,
  output logic                                     fe_ready_o,
  input  logic [FETCH_WIDTH-1:0][ILEN-1:0]         fe_instrs_i,
  input  logic [FETCH_WIDTH-1:0][ILEN-1:0]         fe_pcs_i,
  input  logic [FETCH_WIDTH-1:0]                   fe_slot_valid_i,
  input  logic [FETCH_WIDTH-1:0][ILEN-1:0]         fe_pred_npc_i,
  output logic                                     ibuf2dec_valid_o,
  input  logic                                     dec2ibuf_ready_i,
  output logic [DECODE_WIDTH-1:0][ILEN-1:0]        ibuf_instrs_o,
  output logic [DECODE_WIDTH-1:0][ILEN-1:0]        ibuf_pcs_o,
  output logic [DECODE_WIDTH-1:0]                  ibuf_slot_valid_o,
  output logic [DECODE_WIDTH-1:0][ILEN-1:0]        ibuf_pred_npc_o,
  output logic [$clog2(DEPTH+1)-1:0]               count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [ILEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] npc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] slot_off [FETCH_WIDTH];
  logic             push_en;
  logic             pop_en;

  // Ready looks only at current occupancy so it never depends on the decoder handshake.
  assign fe_ready_o       = !rst_i && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH));
  assign ibuf2dec_valid_o = (count_q != '0);
  assign count_o          = count_q;

  assign push_en = fe_valid_i && fe_ready_o && !flush_i;
  assign pop_en  = ibuf2dec_valid_o && dec2ibuf_ready_i && !flush_i;
  assign pop_cnt = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = push_cnt;
      if (fe_slot_valid_i[i]) begin
        push_cnt = push_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        tail_d = tail_q + PTR_W'(push_cnt);
      end
      if (pop_en) begin
        head_d = head_q + PTR_W'(pop_cnt);
      end
      count_d = count_q + (push_en ? push_cnt : '0) - (pop_en ? pop_cnt : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (fe_slot_valid_i[i]) begin
          instr_mem[tail_q + PTR_W'(slot_off[i])] <= fe_instrs_i[i];
          pc_mem[tail_q + PTR_W'(slot_off[i])]    <= fe_pcs_i[i];
          npc_mem[tail_q + PTR_W'(slot_off[i])]   <= fe_pred_npc_i[i];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out
      logic [PTR_W-1:0] rd_idx;
      logic             slot_vld;
      assign rd_idx                = head_q + PTR_W'(gi);
      assign slot_vld              = (CNT_W'(gi) < count_q);
      assign ibuf_slot_valid_o[gi] = slot_vld;
      assign ibuf_instrs_o[gi]     = slot_vld ? instr_mem[rd_idx] : NOP_INSTR;
      assign ibuf_pcs_o[gi]        = slot_vld ? pc_mem[rd_idx]    : '0;
      assign ibuf_pred_npc_o[gi]   = slot_vld ? npc_mem[rd_idx]   : '0;
    end
  endgenerate

endmodule

// File: tb/tb_ibuf_compact_queue.sv
// Directed bench for ibuf_compact_queue at default parameters (4/4/16/32).
module tb_ibuf_compact_queue;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             fe_valid = 1'b0;
  logic             fe_ready;
  logic [3:0][31:0] fe_instrs = '0;
  logic [3:0][31:0] fe_pcs = '0;
  logic [3:0]       fe_mask = '0;
  logic [3:0][31:0] fe_npc = '0;
  logic             dec_valid;
  logic             dec_ready = 1'b0;
  logic [3:0][31:0] out_instrs;
  logic [3:0][31:0] out_pcs;
  logic [3:0]       out_valid;
  logic [3:0][31:0] out_npc;
  logic [4:0]       count;

  int total = 0;
  int bad   = 0;

  ibuf_compact_queue dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .fe_valid_i       (fe_valid),
    .fe_ready_o       (fe_ready),
    .fe_instrs_i      (fe_instrs),
    .fe_pcs_i         (fe_pcs),
    .fe_slot_valid_i  (fe_mask),
    .fe_pred_npc_i    (fe_npc),
    .ibuf2dec_valid_o (dec_valid),
    .dec2ibuf_ready_i (dec_ready),
    .ibuf_instrs_o    (out_instrs),
    .ibuf_pcs_o       (out_pcs),
    .ibuf_slot_valid_o(out_valid),
    .ibuf_pred_npc_o  (out_npc),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction word is pc + 0x13 and predicted next PC is pc + 4 for every slot.
  task automatic drive_group(input logic [31:0] base, input logic [3:0] mask);
    fe_valid = 1'b1;
    fe_mask  = mask;
    for (int i = 0; i < 4; i++) begin
      fe_pcs[i]    = base + 32'(4 * i);
      fe_instrs[i] = base + 32'(4 * i) + 32'h13;
      fe_npc[i]    = base + 32'(4 * i) + 32'h4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (fe_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_low got %b exp 0", fe_ready);
    end
    rst = 1'b0;
    tick();
    total++;
    if (fe_ready !== 1'b1 || dec_valid !== 1'b0 || count !== 5'd0 || out_valid !== 4'b0) begin
      bad++; $display("FAIL reset_state got ready=%b valid=%b count=%0d sv=%b exp 1 0 0 0000",
                      fe_ready, dec_valid, count, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_instrs[k] !== 32'h13 || out_pcs[k] !== 32'h0 || out_npc[k] !== 32'h0) begin
        bad++; $display("FAIL reset_slot%0d got instr=%h pc=%h npc=%h exp 00000013 0 0",
                        k, out_instrs[k], out_pcs[k], out_npc[k]);
      end
    end
    $display("reset: count=%0d ready=%b", count, fe_ready);
  endtask

  task automatic test_sparse_push();
    dec_ready = 1'b0;
    drive_group(32'h8000_0000, 4'b1010);
    total++;
    if (dec_valid !== 1'b0) begin
      bad++; $display("FAIL sparse_no_bypass got valid=%b exp 0", dec_valid);
    end
    tick();
    fe_valid = 1'b0;
    total++;
    if (count !== 5'd2 || out_valid !== 4'b0011) begin
      bad++; $display("FAIL sparse_count got count=%0d sv=%b exp 2 0011", count, out_valid);
    end
    total++;
    if (out_pcs[0] !== 32'h8000_0004 || out_pcs[1] !== 32'h8000_000C ||
        out_instrs[0] !== 32'h8000_0017 || out_npc[1] !== 32'h8000_0010) begin
      bad++; $display("FAIL sparse_data got pc0=%h pc1=%h i0=%h n1=%h exp 80000004 8000000c 80000017 80000010",
                      out_pcs[0], out_pcs[1], out_instrs[0], out_npc[1]);
    end
    total++;
    if (out_instrs[2] !== 32'h13 || out_pcs[2] !== 32'h0) begin
      bad++; $display("FAIL sparse_invalid_slot got instr=%h pc=%h exp 00000013 0", out_instrs[2], out_pcs[2]);
    end
    $display("sparse push: count=%0d pc0=%h pc1=%h", count, out_pcs[0], out_pcs[1]);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    total++;
    if (count !== 5'd0 || dec_valid !== 1'b0) begin
      bad++; $display("FAIL sparse_drain got count=%0d valid=%b exp 0 0", count, dec_valid);
    end
  endtask

  task automatic test_fill();
    dec_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      drive_group(32'h1000 + 32'(16 * n), 4'hF);
      tick();
      total++;
      if (count !== 5'(4 * (n + 1)) || fe_ready !== ((4 * (n + 1)) <= 12)) begin
        bad++; $display("FAIL fill_%0d got count=%0d ready=%b exp %0d %b",
                        n, count, fe_ready, 4 * (n + 1), (4 * (n + 1)) <= 12);
      end
      $display("fill %0d: count=%0d ready=%b", n, count, fe_ready);
    end
    drive_group(32'h2000, 4'hF);
    tick();
    fe_valid = 1'b0;
    total++;
    if (count !== 5'd16 || fe_ready !== 1'b0) begin
      bad++; $display("FAIL full_ignore got count=%0d ready=%b exp 16 0", count, fe_ready);
    end
    dec_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      total++;
      if (out_pcs[0] !== 32'h1000 + 32'(16 * n) || out_pcs[3] !== 32'h100C + 32'(16 * n) ||
          out_valid !== 4'hF) begin
        bad++; $display("FAIL drain_%0d got pc0=%h pc3=%h sv=%b exp %h %h 1111",
                        n, out_pcs[0], out_pcs[3], out_valid, 32'h1000 + 32'(16 * n), 32'h100C + 32'(16 * n));
      end
      $display("drain %0d: pc0=%h count=%0d", n, out_pcs[0], count);
      tick();
    end
    dec_ready = 1'b0;
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL drain_empty got count=%0d exp 0", count);
    end
  endtask

  task automatic test_partial_pop();
    drive_group(32'h3000, 4'b0111);
    tick();
    fe_valid = 1'b0;
    total++;
    if (count !== 5'd3 || out_valid !== 4'b0111 || out_pcs[2] !== 32'h3008) begin
      bad++; $display("FAIL partial_fill got count=%0d sv=%b pc2=%h exp 3 0111 00003008",
                      count, out_valid, out_pcs[2]);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    total++;
    if (count !== 5'd0 || dec_valid !== 1'b0) begin
      bad++; $display("FAIL partial_pop got count=%0d valid=%b exp 0 0", count, dec_valid);
    end
    $display("partial pop: count=%0d valid=%b", count, dec_valid);
  endtask

  task automatic test_zero_mask();
    drive_group(32'h3800, 4'b0000);
    tick();
    fe_valid = 1'b0;
    total++;
    if (count !== 5'd0 || dec_valid !== 1'b0) begin
      bad++; $display("FAIL zero_mask got count=%0d valid=%b exp 0 0", count, dec_valid);
    end
    $display("zero mask: count=%0d", count);
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_push;
    logic [31:0] exp_out;
    drive_group(32'h4000, 4'hF);
    tick();
    drive_group(32'h4010, 4'hF);
    tick();
    next_push = 32'h4020;
    exp_out   = 32'h4000;
    dec_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_group(next_push, 4'hF);
      total++;
      if (count !== 5'd8 || out_valid !== 4'hF || out_instrs[0] !== exp_out + 32'h13) begin
        bad++; $display("FAIL b2b_state_%0d got count=%0d sv=%b i0=%h exp 8 1111 %h",
                        c, count, out_valid, out_instrs[0], exp_out + 32'h13);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (out_pcs[k] !== exp_out + 32'(4 * k)) begin
          bad++; $display("FAIL b2b_pc_%0d_%0d got %h exp %h", c, k, out_pcs[k], exp_out + 32'(4 * k));
        end
      end
      $display("b2b %0d: count=%0d pc0=%h", c, count, out_pcs[0]);
      tick();
      exp_out   = exp_out + 32'h10;
      next_push = next_push + 32'h10;
    end
    fe_valid  = 1'b0;
    dec_ready = 1'b0;
    total++;
    if (count !== 5'd8 || out_pcs[0] !== exp_out) begin
      bad++; $display("FAIL b2b_end got count=%0d pc0=%h exp 8 %h", count, out_pcs[0], exp_out);
    end
  endtask

  task automatic test_flush();
    total++;
    if (count !== 5'd8) begin
      bad++; $display("FAIL flush_pre got count=%0d exp 8", count);
    end
    drive_group(32'h5000, 4'hF);
    dec_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    fe_valid  = 1'b0;
    dec_ready = 1'b0;
    total++;
    if (count !== 5'd0 || dec_valid !== 1'b0 || out_valid !== 4'b0 || fe_ready !== 1'b1 ||
        out_pcs[0] !== 32'h0) begin
      bad++; $display("FAIL flush_state got count=%0d valid=%b sv=%b ready=%b pc0=%h exp 0 0 0000 1 0",
                      count, dec_valid, out_valid, fe_ready, out_pcs[0]);
    end
    $display("flush: count=%0d valid=%b", count, dec_valid);
    drive_group(32'h6000, 4'b1001);
    tick();
    fe_valid = 1'b0;
    total++;
    if (count !== 5'd2 || out_pcs[0] !== 32'h6000 || out_pcs[1] !== 32'h600C) begin
      bad++; $display("FAIL flush_refill got count=%0d pc0=%h pc1=%h exp 2 00006000 0000600c",
                      count, out_pcs[0], out_pcs[1]);
    end
    $display("refill: count=%0d pc0=%h pc1=%h", count, out_pcs[0], out_pcs[1]);
  endtask

  initial begin
    test_reset();
    test_sparse_push();
    test_fill();
    test_partial_pop();
    test_zero_mask();
    test_back_to_back();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibuf_compact_queue.md
IBUF_COMPACT_QUEUE -- requirements
Module: ibuf_compact_queue

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4, instruction slots per fetch group.
REQ-002 SHALL have parameter DECODE_WIDTH, default 4, instruction slots presented to decoder per cycle.
REQ-003 SHALL have parameter DEPTH, default 16, queue entries; power of 2, >= 2*FETCH_WIDTH, >= DECODE_WIDTH.
REQ-004 SHALL have parameter ILEN, default 32, instruction and PC width.
REQ-005 SHALL have port clk_i  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_i  in  1  discard all queued entries.
REQ-008 SHALL have port fe_valid_i  in  1  fetch group offered.
REQ-009 SHALL have port fe_ready_o  out  1  queue can accept a full group.
REQ-010 SHALL have port fe_instrs_i  in  FETCH_WIDTH x ILEN  fetched instructions.
REQ-011 SHALL have port fe_pcs_i  in  FETCH_WIDTH x ILEN  per-slot PC.
REQ-012 SHALL have port fe_slot_valid_i  in  FETCH_WIDTH  per-slot valid mask, may be non-contiguous.
REQ-013 SHALL have port fe_pred_npc_i  in  FETCH_WIDTH x ILEN  per-slot predicted next PC.
REQ-014 SHALL have port ibuf2dec_valid_o  out  1  at least one entry presented.
REQ-015 SHALL have port dec2ibuf_ready_i  in  1  decoder consumes presented slots.
REQ-016 SHALL have port ibuf_instrs_o  out  DECODE_WIDTH x ILEN  presented instructions.
REQ-017 SHALL have port ibuf_pcs_o  out  DECODE_WIDTH x ILEN  presented PCs.
REQ-018 SHALL have port ibuf_slot_valid_o  out  DECODE_WIDTH  presented slot valid, always contiguous from slot 0.
REQ-019 SHALL have port ibuf_pred_npc_o  out  DECODE_WIDTH x ILEN  presented predicted next PC.
REQ-020 SHALL have port count_o  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-021 SHALL store entries {instr, pc, pred_npc} in a circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-022 SHALL drive fe_ready_o = (DEPTH - count >= FETCH_WIDTH), from current state only, ignoring same-cycle pop.
REQ-023 SHALL push when fe_valid_i & fe_ready_o & !flush_i: valid slots compacted in ascending slot index into consecutive entries from tail; tail += popcount(fe_slot_valid_i).
REQ-024 SHALL treat an accepted group with mask all-zero as no-op (no state change).
REQ-025 SHALL drive ibuf2dec_valid_o = (count != 0).
REQ-026 SHALL present slot k valid iff k < min(count, DECODE_WIDTH), carrying entry (head+k) mod DEPTH.
REQ-027 SHALL drive invalid output slots as instr 32'h00000013, pc 0, pred_npc 0.
REQ-028 SHALL pop min(count, DECODE_WIDTH) entries when ibuf2dec_valid_o & dec2ibuf_ready_i & !flush_i; head advances accordingly.
REQ-029 SHALL update count_next = count - pop + push on simultaneous push and pop.
REQ-030 SHALL not bypass: pushed entries become visible at output one cycle after acceptance minimum.
REQ-031 SHALL give flush_i top priority: next cycle head=tail=count=0; same-cycle push and pop discarded.
REQ-032 SHALL drive all outputs combinationally from registered state; no combinational path fe_* -> ibuf*_o.
REQ-033 SHALL preserve program order across pointer wrap-around.

Reset
REQ-034 SHALL, while rst_i high at a clock edge, set head=tail=count=0; rst_i dominates flush_i and push/pop.
REQ-035 SHALL drive fe_ready_o=0 while rst_i is high; after reset: fe_ready_o=1, ibuf2dec_valid_o=0, count_o=0, ibuf_slot_valid_o=0, all slots NOP/0.
REQ-036 SHALL leave buffer storage contents unreset; unpresented entries are don't-care.

Verification (defaults 4/4/16)
REQ-037 SHALL cover: reset release -> fe_ready_o=1, ibuf2dec_valid_o=0, count_o=0, slots 32'h00000013/pc 0.
REQ-038 SHALL cover: push pcs 0x80000000..0x8000000C mask 4'b1010, ready=0 -> next cycle count_o=2, slot_valid 4'b0011, slot0 pc 0x80000004, slot1 pc 0x8000000C.
REQ-039 SHALL cover: 4 full pushes, dec ready=0 -> count 4,8,12,16; fe_ready_o=1 at 12, 0 at 16; further fe_valid_i ignored.
REQ-040 SHALL cover: count=3, ready=1, no push -> pop 3, count_o=0 next cycle, ibuf2dec_valid_o=0.
REQ-041 SHALL cover: 10 cycles simultaneous full push and pop from count=8 -> count stays 8, PCs leave strictly ascending through head/tail wrap.
REQ-042 SHALL cover: flush_i with fe_valid_i=1 and ready=1 at count=8 -> next cycle count_o=0, valid=0, pushed group lost.
